// File: rtl/card_regfile_ctl_rr.sv
// Card regfile control: round-robin arbitration of NUM_CH write channels onto the
// single regfile write port, plus a read-address driver with single-follow and range-scan modes.
module card_regfile_ctl_rr #(
  parameter int unsigned DATA_W  = 14,
  parameter int unsigned STATE_W = 2,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_CH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          wr_valid,
  output logic [NUM_CH-1:0]          wr_ready,
  input  logic [NUM_CH-1:0]          wr_mode,
  input  logic [NUM_CH*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_CH*DATA_W-1:0]   wr_data,
  output logic [1:0]                 regfile_w_enable,
  output logic [ADDR_W-1:0]          regfile_w_address,
  output logic [DATA_W-1:0]          regfile_w_data,
  input  logic [ADDR_W-1:0]          rd_one_addr,
  input  logic                       scan_start,
  input  logic [ADDR_W-1:0]          scan_first,
  input  logic [ADDR_W-1:0]          scan_last,
  output logic [ADDR_W-1:0]          regfile_r_address,
  output logic                       scan_valid,
  output logic                       scan_busy,
  output logic                       scan_done
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, SCAN} state_e;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  gnt_idx, cand;
  logic              gnt_any;
  logic              g_mode;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;

  logic [1:0]        w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Search upward from the pointer; the first valid channel wins the port.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    wr_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = PTR_W'((32'(ptr_q) + i) % NUM_CH);
      if (!gnt_any && wr_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) wr_ready[gnt_idx] = 1'b1;
    ptr_d = gnt_any ? PTR_W'((32'(gnt_idx) + 32'd1) % NUM_CH) : ptr_q;
  end

  // Registered write port payload; state-only writes clear the upper data bits.
  always_comb begin
    g_mode   = wr_mode[gnt_idx];
    g_addr   = wr_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
    g_data   = wr_data[32'(gnt_idx)*DATA_W +: DATA_W];
    w_en_d   = 2'b00;
    w_addr_d = '0;
    w_data_d = '0;
    if (gnt_any) begin
      w_en_d   = {g_mode, ~g_mode};
      w_addr_d = g_addr;
      w_data_d = g_mode ? {{(DATA_W-STATE_W){1'b0}}, g_data[STATE_W-1:0]} : g_data;
    end
  end

  // Read address FSM: follow rd_one_addr in IDLE, walk first..last in SCAN.
  always_comb begin
    state_d  = state_q;
    r_addr_d = r_addr_q;
    last_d   = last_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        r_addr_d = rd_one_addr;
        if (scan_start) begin
          r_addr_d = scan_first;
          last_d   = (scan_last < scan_first) ? scan_first : scan_last;
          valid_d  = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (r_addr_q == last_q) begin
          r_addr_d = rd_one_addr;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          r_addr_d = r_addr_q + ADDR_W'(1);
          valid_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      w_en_q   <= 2'b00;
      w_addr_q <= '0;
      w_data_q <= '0;
      state_q  <= IDLE;
      r_addr_q <= '0;
      last_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      state_q  <= state_d;
      r_addr_q <= r_addr_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign regfile_w_enable  = w_en_q;
  assign regfile_w_address = w_addr_q;
  assign regfile_w_data    = w_data_q;
  assign regfile_r_address = r_addr_q;
  assign scan_valid        = valid_q;
  assign scan_busy         = busy_q;
  assign scan_done         = done_q;

endmodule

// File: tb/tb_card_regfile_ctl_rr.sv
// Bench for card_regfile_ctl_rr: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a queue-based behavioural model.
module tb_card_regfile_ctl_rr;
  localparam int unsigned DATA_W  = 14;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NUM_CH  = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        wr_valid = '0;
  logic [NUM_CH-1:0]        wr_ready;
  logic [NUM_CH-1:0]        wr_mode = '0;
  logic [NUM_CH*ADDR_W-1:0] wr_addr = '0;
  logic [NUM_CH*DATA_W-1:0] wr_data = '0;
  logic [1:0]               regfile_w_enable;
  logic [ADDR_W-1:0]        regfile_w_address;
  logic [DATA_W-1:0]        regfile_w_data;
  logic [ADDR_W-1:0]        rd_one_addr = '0;
  logic                     scan_start = 1'b0;
  logic [ADDR_W-1:0]        scan_first = '0;
  logic [ADDR_W-1:0]        scan_last = '0;
  logic [ADDR_W-1:0]        regfile_r_address;
  logic                     scan_valid, scan_busy, scan_done;

  card_regfile_ctl_rr #(.DATA_W(DATA_W), .STATE_W(STATE_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_mode(wr_mode),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .regfile_w_enable(regfile_w_enable), .regfile_w_address(regfile_w_address),
    .regfile_w_data(regfile_w_data),
    .rd_one_addr(rd_one_addr), .scan_start(scan_start),
    .scan_first(scan_first), .scan_last(scan_last),
    .regfile_r_address(regfile_r_address), .scan_valid(scan_valid),
    .scan_busy(scan_busy), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state
  int                mptr = 0;
  logic [ADDR_W-1:0] scan_q[$];
  bit                in_scan = 1'b0;
  logic [1:0]        exp_wen = '0;
  logic [ADDR_W-1:0] exp_wa = '0;
  logic [DATA_W-1:0] exp_wd = '0;
  logic [ADDR_W-1:0] exp_ra = '0;
  logic              exp_sv = 1'b0, exp_sb = 1'b0, exp_sd = 1'b0;
  int                last_g = -1;
  logic [NUM_CH-1:0] seen_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // One clock: check ready, predict next outputs from the rules, step, check outputs.
  task automatic cycle();
    int g;
    logic [NUM_CH-1:0] er, t;
    logic [ADDR_W-1:0] eff;
    logic [DATA_W-1:0] d;
    #1;
    g = -1;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      int c;
      c = (mptr + k) % int'(NUM_CH);
      t = wr_valid >> c;
      if (g < 0 && t[0]) g = c;
    end
    er = '0;
    if (g >= 0) er = NUM_CH'(1) << g;
    seen_ready = wr_ready;
    chk("wr_ready", 32'(wr_ready), 32'(er));
    last_g = g;
    if (rst) begin
      mptr = 0; scan_q.delete(); in_scan = 1'b0;
      exp_wen = '0; exp_wa = '0; exp_wd = '0;
      exp_ra = '0; exp_sv = 1'b0; exp_sb = 1'b0; exp_sd = 1'b0;
    end else begin
      if (g >= 0) begin
        t = wr_mode >> g;
        d = wr_data[g*DATA_W +: DATA_W];
        exp_wen = t[0] ? 2'b10 : 2'b01;
        exp_wa  = wr_addr[g*ADDR_W +: ADDR_W];
        exp_wd  = t[0] ? DATA_W'(d % (1 << STATE_W)) : d;
        mptr    = (g + 1) % int'(NUM_CH);
      end else begin
        exp_wen = '0; exp_wa = '0; exp_wd = '0;
      end
      if (scan_q.size() > 0) begin
        exp_ra = scan_q.pop_front(); exp_sv = 1'b1; exp_sb = 1'b1; exp_sd = 1'b0;
      end else if (in_scan) begin
        exp_ra = rd_one_addr; exp_sv = 1'b0; exp_sb = 1'b0; exp_sd = 1'b1; in_scan = 1'b0;
      end else if (scan_start) begin
        eff = (scan_last < scan_first) ? scan_first : scan_last;
        for (int a = int'(scan_first); a <= int'(eff); a++) scan_q.push_back(ADDR_W'(a));
        exp_ra = scan_q.pop_front(); exp_sv = 1'b1; exp_sb = 1'b1; exp_sd = 1'b0;
        in_scan = 1'b1;
      end else begin
        exp_ra = rd_one_addr; exp_sv = 1'b0; exp_sb = 1'b0; exp_sd = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("w_enable", 32'(regfile_w_enable), 32'(exp_wen));
    chk("w_address", 32'(regfile_w_address), 32'(exp_wa));
    chk("w_data", 32'(regfile_w_data), 32'(exp_wd));
    chk("r_address", 32'(regfile_r_address), 32'(exp_ra));
    chk("scan_valid", 32'(scan_valid), 32'(exp_sv));
    chk("scan_busy", 32'(scan_busy), 32'(exp_sb));
    chk("scan_done", 32'(scan_done), 32'(exp_sd));
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = '0; scan_start = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  logic [NUM_CH-1:0] pend;
  int                age [NUM_CH];
  int                ncnt [NUM_CH];

  initial begin
    // Reset state, then follow rd_one_addr
    do_reset();
    chk("rst_w_enable", 32'(regfile_w_enable), 32'd0);
    chk("rst_w_data", 32'(regfile_w_data), 32'd0);
    chk("rst_r_address", 32'(regfile_r_address), 32'd0);
    chk("rst_scan_busy", 32'(scan_busy), 32'd0);
    rd_one_addr = 5'd7;
    cycle();
    chk("follow_addr", 32'(regfile_r_address), 32'd7);
    chk("idle_w_enable", 32'(regfile_w_enable), 32'd0);

    // State-only write on ch1
    wr_valid = 2'b10; wr_mode = 2'b10;
    wr_addr[ADDR_W +: ADDR_W] = 5'd5;
    wr_data[DATA_W +: DATA_W] = 14'h3FFF;
    cycle();
    chk("so_ready", 32'(seen_ready), 32'd2);
    chk("so_enable", 32'(regfile_w_enable), 32'd2);
    chk("so_address", 32'(regfile_w_address), 32'd5);
    chk("so_data", 32'(regfile_w_data), 32'h0003);
    wr_valid = '0; wr_mode = '0;
    cycle();

    // Both channels valid continuously: grants alternate, each payload lands one cycle later
    do_reset();
    ncnt[0] = 0; ncnt[1] = 0;
    wr_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      int gc;
      for (int c = 0; c < 2; c++) begin
        wr_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(c*16 + ncnt[c]);
        wr_data[c*DATA_W +: DATA_W] = DATA_W'(c*1000 + ncnt[c]);
      end
      gc = k % 2;
      cycle();
      chk("alt_ready", 32'(seen_ready), (gc == 0) ? 32'd1 : 32'd2);
      chk("alt_addr", 32'(regfile_w_address), 32'(gc*16 + ncnt[gc]));
      chk("alt_data", 32'(regfile_w_data), 32'(gc*1000 + ncnt[gc]));
      ncnt[gc]++;
    end
    wr_valid = '0;

    // Scan 0..19 with an ignored restart mid-scan
    rd_one_addr = 5'd7; scan_first = 5'd0; scan_last = 5'd19; scan_start = 1'b1;
    cycle();
    for (int i = 0; i < 20; i++) begin
      chk("scan_addr", 32'(regfile_r_address), 32'(i));
      chk("scan_valid_on", 32'(scan_valid), 32'd1);
      chk("scan_done_low", 32'(scan_done), 32'd0);
      scan_start = (i == 5);
      if (i == 5) begin scan_first = 5'd2; scan_last = 5'd3; end
      cycle();
    end
    chk("scan_end_done", 32'(scan_done), 32'd1);
    chk("scan_end_valid", 32'(scan_valid), 32'd0);
    chk("scan_end_addr", 32'(regfile_r_address), 32'd7);
    cycle();
    chk("scan_done_pulse", 32'(scan_done), 32'd0);

    // Reversed range: single-address scan
    scan_first = 5'd9; scan_last = 5'd3; scan_start = 1'b1;
    cycle();
    scan_start = 1'b0;
    chk("rev_addr", 32'(regfile_r_address), 32'd9);
    chk("rev_valid", 32'(scan_valid), 32'd1);
    cycle();
    chk("rev_done", 32'(scan_done), 32'd1);
    chk("rev_valid_off", 32'(scan_valid), 32'd0);
    cycle();

    // Reset mid-scan at address 4
    scan_first = 5'd0; scan_last = 5'd10; scan_start = 1'b1;
    cycle();
    scan_start = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("pre_rst_addr", 32'(regfile_r_address), 32'd4);
    rst = 1'b1;
    cycle();
    chk("midrst_addr", 32'(regfile_r_address), 32'd0);
    chk("midrst_valid", 32'(scan_valid), 32'd0);
    chk("midrst_busy", 32'(scan_busy), 32'd0);
    chk("midrst_done", 32'(scan_done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("no_done_after_rst", 32'(scan_done), 32'd0);
    end

    // Randomized traffic
    pend = '0;
    for (int c = 0; c < int'(NUM_CH); c++) age[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (!pend[c] && $urandom_range(0, 2) == 0) begin
          pend[c] = 1'b1;
          wr_addr[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
          wr_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
          wr_mode[c] = 1'($urandom_range(0, 1));
        end
      end
      wr_valid    = rst ? '0 : pend;
      rd_one_addr = ADDR_W'($urandom);
      scan_start  = ($urandom_range(0, 9) == 0);
      scan_first  = ADDR_W'($urandom);
      scan_last   = ADDR_W'($urandom);
      cycle();
      if (last_g >= 0) pend[last_g] = 1'b0;
      if (!rst) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          age[c] = pend[c] ? age[c] + 1 : 0;
          chk("no_starve", 32'(age[c] <= int'(NUM_CH)), 32'd1);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/card_regfile_ctl_rr.md
Name: card_regfile_ctl_rr

Overview:
- Parametrised successor to the card register-file control unit. Arbitrates NUM_CH independent write channels onto the single card regfile write port using valid/ready handshakes and round-robin fairness. Simultaneous writers are stalled, never silently dropped.
- Drives the regfile read address in two modes: single-card follow, or an inclusive range scan with a valid strobe and a done pulse.
- Sits between the game-logic/animation masters and the card regfile.

Parameters:
- DATA_W, 14: full card data width; the low STATE_W bits are the card state.
- STATE_W, 2: card state field width.
- ADDR_W, 5: card address width.
- NUM_CH, 2: number of write channels (1..8).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_valid  in  NUM_CH  per-channel write request
- wr_ready  out  NUM_CH  per-channel grant; a transfer occurs when valid&ready
- wr_mode  in  NUM_CH  per channel: 0 = full write, 1 = state-only write
- wr_addr  in  NUM_CH*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
- wr_data  in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]; state-only mode uses the low STATE_W bits
- regfile_w_enable  out  2  bit0 = full write, bit1 = state-only write (one-hot or zero)
- regfile_w_address  out  ADDR_W  registered write address
- regfile_w_data  out  DATA_W  registered write data
- rd_one_addr  in  ADDR_W  address to follow when not scanning
- scan_start  in  1  start a range scan (pulse)
- scan_first  in  ADDR_W  first scan address
- scan_last  in  ADDR_W  last scan address, inclusive
- regfile_r_address  out  ADDR_W  registered read address
- scan_valid  out  1  high while regfile_r_address is a scan address
- scan_busy  out  1  high in SCAN state
- scan_done  out  1  one-cycle pulse after the last scan address

Behaviour:
- Reset:
  - All registered outputs are 0: regfile_w_enable, regfile_w_address, regfile_w_data, regfile_r_address, scan_valid, scan_busy, scan_done.
  - Round-robin pointer is 0; state is IDLE.
- Write arbitration:
  - wr_ready is combinational from wr_valid and the pointer.
  - The search starts at the pointer and goes upward modulo NUM_CH. The first channel found with valid set gets ready=1; all others get 0. At most one ready bit is high.
  - On a grant to channel g, the pointer becomes (g+1) mod NUM_CH. With no valid channel, the pointer holds.
  - Latency is 1: the cycle after a grant, regfile_w_enable = {mode_g, ~mode_g} and regfile_w_address = wr_addr[g].
  - Full mode: regfile_w_data = wr_data[g].
  - State-only mode: upper DATA_W-STATE_W data bits = 0; low STATE_W bits = wr_data[g] low bits.
  - With no grant: regfile_w_enable = 0 and address/data are driven to 0.
  - A requester holds valid/addr/data/mode stable until it receives ready; an ungranted request is never lost.
  - NUM_CH=1: ready = valid.
- Read FSM, IDLE state:
  - regfile_r_address <= rd_one_addr each cycle.
  - scan_valid = 0.
  - On scan_start: regfile_r_address <= scan_first, scan_valid <= 1, go to SCAN.
  - If scan_last < scan_first, the effective last address is scan_first (single-address scan).
- Read FSM, SCAN state:
  - If regfile_r_address == effective last: regfile_r_address <= rd_one_addr, scan_valid <= 0, scan_done <= 1 for one cycle, go to IDLE.
  - Otherwise increment by 1; no wrap, because the last address is bounded.
  - scan_first and scan_last are latched at start; input changes during a scan are ignored.
  - scan_start while busy is ignored.
  - scan_busy = (state == SCAN).
- A scan of N addresses gives exactly N consecutive cycles of scan_valid=1, followed by the scan_done pulse in the cycle after the last one.
- The read and write paths are independent; writes proceed during a scan.
- rst mid-scan aborts the scan: IDLE, outputs 0, no scan_done.

Test Plan:
- Reset, then idle with rd_one_addr=7: regfile_r_address=7 one cycle later; all write outputs are 0.
- ch0 and ch1 both valid continuously, pointer=0: grants alternate 0,1,0,1; each write appears on regfile_w_* one cycle after its grant, and no request is lost.
- ch1 state-only write, addr=5, data=14'h3FFF: next cycle enable=2'b10, address=5, data=14'h0003.
- scan_start with first=0, last=19: 20 consecutive cycles with addresses 0..19 and scan_valid=1, then scan_done for one cycle, then return to following rd_one_addr; a second scan_start issued mid-scan is ignored.
- scan_first=9, scan_last=3: exactly one scan cycle at address 9, then scan_done.
- rst asserted during a scan at address 4: the next cycle has every output at 0 and scan_done never pulses.
